// File: rtl/seqdet_sched.sv
// seqdet_sched: round-robin scheduler sharing one serial "two zeros in a row" detector among N_CH requesters.
// Define SEQDET_CTX_EN to keep each channel's detector history across frames; otherwise history starts invalid.
module seqdet_sched #(
   parameter  int N_CH    = 4,
   parameter  int FRAME_W = 8,
   localparam int HW      = $clog2(FRAME_W + 1),
   localparam int CW      = $clog2(N_CH),
   localparam int IW      = $clog2(FRAME_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         req_valid,
   input  logic [N_CH*FRAME_W-1:0] req_data,
   output logic [N_CH-1:0]         req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CW-1:0]           res_ch,
   output logic [FRAME_W-1:0]      res_mask,
   output logic [HW-1:0]           res_hits
);

   localparam int P = 1 << $clog2(FRAME_W);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [FRAME_W-1:0]      r_frame, r_mask, w_gdata;
   logic [IW-1:0]           r_idx;
   logic [CW-1:0]           r_ch, r_last, w_gidx;
   logic                    r_hist, r_hist_vld;
   logic                    w_any, w_accept, w_bit, w_hit, w_ctx_bit, w_ctx_vld;
   logic [N_CH-1:0][CW-1:0] w_cand;
   logic [P-1:0][HW-1:0]    w_sum;

   // Candidate k is the (k+1)-th channel after the last grant, wrapping.
   for (genvar k = 0; k < N_CH; k++) begin : g_cand
      assign w_cand[k] = CW'((int'(r_last) + k + 1) % N_CH);
   end

   always_comb begin
      w_any  = 1'b0;
      w_gidx = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!w_any && req_valid[w_cand[k]]) begin
            w_any  = 1'b1;
            w_gidx = w_cand[k];
         end
      end
   end

   always_comb begin
      w_gdata = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_gidx == CW'(c)) w_gdata = req_data[c*FRAME_W +: FRAME_W];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               req_ready   = {{(N_CH-1){1'b0}}, 1'b1} << w_gidx;
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: if (r_idx == '0) w_state_nxt = S_DONE;
         S_DONE:  if (res_ready)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_bit = r_frame[r_idx];
   assign w_hit = !w_bit && r_hist_vld && !r_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_frame    <= '0;
         r_mask     <= '0;
         r_idx      <= '0;
         r_ch       <= '0;
         r_last     <= CW'(N_CH - 1);
         r_hist     <= 1'b0;
         r_hist_vld <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_frame    <= w_gdata;
            r_ch       <= w_gidx;
            r_last     <= w_gidx;
            r_mask     <= '0;
            r_idx      <= IW'(FRAME_W - 1);
            r_hist     <= w_ctx_bit;
            r_hist_vld <= w_ctx_vld;
         end
         if (r_state == S_SHIFT) begin
            r_mask[r_idx] <= w_hit;
            r_hist        <= w_bit;
            r_hist_vld    <= 1'b1;
            r_idx         <= r_idx - IW'(1);
         end
      end
   end

`ifdef SEQDET_CTX_EN
   logic [N_CH-1:0] r_ctx_bit, r_ctx_vld;

   // Context is committed only when the last bit of a frame is shifted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctx_bit <= '0;
         r_ctx_vld <= '0;
      end else if (r_state == S_SHIFT && r_idx == '0) begin
         r_ctx_bit[r_ch] <= w_bit;
         r_ctx_vld[r_ch] <= 1'b1;
      end
   end

   assign w_ctx_bit = r_ctx_bit[w_gidx];
   assign w_ctx_vld = r_ctx_vld[w_gidx];
`else
   assign w_ctx_bit = 1'b0;
   assign w_ctx_vld = 1'b0;
`endif

   // Pairwise reduction, halving the active width each level.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < FRAME_W; i++) w_sum[i] = HW'(r_mask[i]);
      for (int s = P / 2; s > 0; s = s / 2) begin
         for (int i = 0; i < s; i++) w_sum[i] = w_sum[2*i] + w_sum[2*i+1];
      end
   end

   assign res_valid = (r_state == S_DONE);
   assign res_ch    = r_ch;
   assign res_mask  = r_mask;
   assign res_hits  = w_sum[0];

endmodule

// File: tb/tb_seqdet_sched.sv
// Bench for seqdet_sched (N_CH=4, FRAME_W=8): vector table through a result scoreboard,
// plus round-robin, backpressure and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_seqdet_sched;
   localparam int N_CH = 4, FRAME_W = 8, HW = 4, CW = 2;

   logic                    clk = 1'b0, rst = 1'b1;
   logic [N_CH-1:0]         req_valid = '0;
   logic [N_CH*FRAME_W-1:0] req_data = '0;
   logic [N_CH-1:0]         req_ready;
   logic                    res_valid;
   logic                    res_ready = 1'b1;
   logic [CW-1:0]           res_ch;
   logic [FRAME_W-1:0]      res_mask;
   logic [HW-1:0]           res_hits;

   typedef struct packed {
      logic [CW-1:0]      ch;
      logic [FRAME_W-1:0] mask;
      logic [HW-1:0]      hits;
   } res_t;

   typedef struct {
      int          ch;
      logic [7:0]  data;
      logic [7:0]  mask;
      logic [3:0]  hits;
   } vec_t;

   int   n_checks = 0, n_errors = 0;
   res_t sb[$];
   res_t exp_ch[N_CH];
   res_t mon_e;
   int   gnt_log[$];

   always #5 clk = ~clk;

   seqdet_sched #(.N_CH(N_CH), .FRAME_W(FRAME_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_ch(res_ch), .res_mask(res_mask), .res_hits(res_hits)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Grants push the expected result for that channel; handshakes pop and compare.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_ready != '0) begin
            check("grant_onehot", 32'($onehot(req_ready)), 1);
            check("grant_needs_valid", 32'(req_ready & ~req_valid), 0);
            for (int c = 0; c < N_CH; c++) begin
               if (req_ready[c] && req_valid[c]) begin
                  gnt_log.push_back(c);
                  sb.push_back(exp_ch[c]);
               end
            end
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_res_valid", 32'(res_valid), 0);
            end else begin
               mon_e = sb.pop_front();
               check("res_ch",   32'(res_ch),   32'(mon_e.ch));
               check("res_mask", 32'(res_mask), 32'(mon_e.mask));
               check("res_hits", 32'(res_hits), 32'(mon_e.hits));
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_grant(input int ch);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready[ch] && n < 50) begin @(negedge clk); n++; end
      check("grant_wait", 32'(req_ready[ch]), 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_result(input string name);
      int n;
      n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
      check(name, n, FRAME_W);
   endtask

   task automatic run_vec(input vec_t v);
      exp_ch[v.ch] = '{ch: CW'(v.ch), mask: v.mask, hits: v.hits};
      req_data[v.ch*FRAME_W +: FRAME_W] = v.data;
      req_valid[v.ch] = 1'b1;
      wait_grant(v.ch);
      req_valid[v.ch] = 1'b0;
      wait_result("latency");
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_res_ch"},    32'(res_ch),    0);
      check({tag, "_res_mask"},  32'(res_mask),  0);
      check({tag, "_res_hits"},  32'(res_hits),  0);
   endtask

   initial begin
      vec_t vt[12];
      int   rr_all[5];
      int   rr_odd[4];
      int   seen;

      vt[0]  = '{0, 8'h91, 8'h26, 4'd3};
      vt[1]  = '{2, 8'h00, 8'h7F, 4'd7};
      vt[3]  = '{1, 8'hFF, 8'h00, 4'd0};
      vt[4]  = '{1, 8'h00, 8'h7F, 4'd7};
      vt[5]  = '{3, 8'hAA, 8'h00, 4'd0};
      vt[7]  = '{0, 8'h00, 8'h7F, 4'd7};
      vt[8]  = '{0, 8'h80, 8'h3F, 4'd6};
`ifdef SEQDET_CTX_EN
      vt[2]  = '{2, 8'h00, 8'hFF, 4'd8};
      vt[6]  = '{3, 8'h55, 8'h80, 4'd1};
      vt[9]  = '{2, 8'h0F, 8'hF0, 4'd4};
      vt[10] = '{1, 8'h49, 8'h92, 4'd3};
      vt[11] = '{0, 8'h01, 8'hFE, 4'd7};
`else
      vt[2]  = '{2, 8'h00, 8'h7F, 4'd7};
      vt[6]  = '{3, 8'h55, 8'h00, 4'd0};
      vt[9]  = '{2, 8'h0F, 8'h70, 4'd3};
      vt[10] = '{1, 8'h49, 8'h12, 4'd2};
      vt[11] = '{0, 8'h01, 8'h7E, 4'd6};
`endif
      rr_all = '{0, 1, 2, 3, 0};
      rr_odd = '{1, 3, 1, 3};

      do_reset();
      check_reset_outputs("reset");

      for (int i = 0; i < 12; i++) run_vec(vt[i]);

      // Round-robin with every channel requesting from reset, then only ch1/ch3.
      do_reset();
      for (int c = 0; c < N_CH; c++) exp_ch[c] = '{CW'(c), 8'h00, 4'd0};
      req_data = {N_CH{8'hFF}};
      gnt_log.delete();
      req_valid = 4'hF;
      seen = 0;
      while (gnt_log.size() < 5 && seen < 100) begin @(negedge clk); seen++; end
      @(posedge clk); #1 req_valid = '0;
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++)
         check("rr_all_order", (i < gnt_log.size()) ? gnt_log[i] : -1, rr_all[i]);

      gnt_log.delete();
      req_valid = 4'b1010;
      seen = 0;
      while (gnt_log.size() < 4 && seen < 100) begin @(negedge clk); seen++; end
      @(posedge clk); #1 req_valid = '0;
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         check("rr_odd_order", (i < gnt_log.size()) ? gnt_log[i] : -1, rr_odd[i]);

      // Backpressure: result held while ch3 waits, ch3 granted right after the handshake.
      exp_ch[0] = '{2'd0, 8'h26, 4'd3};
      exp_ch[3] = '{2'd3, 8'h00, 4'd0};
      req_data[7:0]   = 8'h91;
      req_data[31:24] = 8'hFF;
      res_ready = 1'b0;
      req_valid = 4'b1001;
      wait_grant(0);
      req_valid[0] = 1'b0;
      wait_result("bp_latency");
      for (int i = 0; i < 5; i++) begin
         check("bp_res_valid", 32'(res_valid), 1);
         check("bp_res_ch",    32'(res_ch),    0);
         check("bp_res_mask",  32'(res_mask),  32'h26);
         check("bp_res_hits",  32'(res_hits),  3);
         check("bp_req_ready", 32'(req_ready), 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_next_grant", 32'(req_ready), 32'b1000);
      @(posedge clk); #1 req_valid[3] = 1'b0;
      wait_result("bp_ch3_latency");
      @(posedge clk); #1;

      // Reset while bit index 4 is about to be processed; ch0 context is 0/valid beforehand.
      run_vec('{0, 8'h00, 8'h7F, 4'd7});
      exp_ch[0] = '{2'd0, 8'hFF, 4'd8};
      req_data[7:0] = 8'h00;
      req_valid[0] = 1'b1;
      wait_grant(0);
      req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      check_reset_outputs("midrst");
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (res_valid) seen = 1;
      end
      check("midrst_no_result", seen, 0);
      run_vec('{0, 8'h00, 8'h7F, 4'd7});
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seqdet_sched.md
# seqdet_sched

Round-robin scheduler that shares one serial pattern-detector datapath among `N_CH` requesters. Each requester submits a `FRAME_W`-bit frame over a valid/ready handshake. The block grants one frame at a time and shifts it MSB-first through the detector, one bit per cycle. It saves and restores each channel's detector history and returns a per-frame hit mask and hit count over a valid/ready result port.

## Interface
- `N_CH`, 4: number of requesters, 2..8.
- `FRAME_W`, 8: frame width in bits, 2..16.
- `HW`, `$clog2(FRAME_W+1)`: hit-count width, derived; do not override.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `N_CH`: per-channel frame valid.
- `req_data` in `N_CH*FRAME_W`: channel c occupies bits `[c*FRAME_W +: FRAME_W]`.
- `req_ready` out `N_CH`: one-hot grant; at most one bit high.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_ch` out `$clog2(N_CH)`: channel the result belongs to.
- `res_mask` out `FRAME_W`: bit p set when frame bit p produced a hit.
- `res_hits` out `HW`: popcount of `res_mask`.

## Operation
- **Detector rule:** bit p hits when bit p = 0 and the previously processed bit of the same channel's stream = 0.
  - The "previous bit" of bit `FRAME_W-1` is the channel context.
- **Per-channel context:** `ctx_bit[c]` (last bit processed) and `ctx_vld[c]`.
  - Reset: all `ctx_vld` = 0.
  - When `ctx_vld` = 0, bit `FRAME_W-1` cannot hit.
- **FSM states:** IDLE, SHIFT, DONE.
  - **IDLE:** if any `req_valid`, grant the channel chosen by round-robin. `req_ready[g]` = 1, combinational, only in IDLE.
    - On the accepting edge: latch frame, latch `g`, load history from context, clear mask, set bit index = `FRAME_W-1`, go to SHIFT.
  - **SHIFT:** each cycle, evaluate bit[index] against history and set `mask[index]` on a hit. History becomes bit[index]; index decrements.
    - After index 0 is processed: write `ctx_bit[g]` = bit 0, `ctx_vld[g]` = 1, go to DONE.
  - **DONE:** `res_valid` = 1 and outputs stable until `res_valid & res_ready`, then go to IDLE. No new grant while in DONE.
- **Round-robin:** search starts at `last_grant+1` mod `N_CH` and wraps.
  - `last_grant` updates on the accepting edge only.
  - Reset value `N_CH-1`, so channel 0 wins first.
- **Requests:** a requester may drop `req_valid` before it is granted without consequence. `req_data` is sampled only on the accepting edge.
- **Hit count:** `res_hits` is computed from `res_mask` with an adder tree, width `HW`. No overflow is possible; the maximum is `FRAME_W`.

## Timing
- **Reset values:** `req_ready` = 0, `res_valid` = 0, `res_ch` = 0, `res_mask` = 0, `res_hits` = 0. FSM = IDLE.
- **Latency:** accept at edge E0; bits are processed on edges E1..E`FRAME_W`; `res_valid` is high in the cycle after edge E`FRAME_W`.
- **Throughput:** a result is held at least 1 cycle. Minimum frame period is `FRAME_W+2` cycles with `res_ready` tied high.
- **Same-channel re-request:** a channel back-to-back with itself is granted again only if no other channel is requesting.
- **Reset mid-frame or in DONE:** abort the frame and produce no result. Contexts are cleared and `last_grant` returns to `N_CH-1` on that edge.
- **Backpressure:** `res_ready` low in DONE holds all result outputs and blocks every grant indefinitely.

## Configuration
- Macro `SEQDET_CTX_EN`.
- **Defined:** per-channel context carries across frames as described above.
- **Undefined:** no context registers are built. History is forced invalid at every frame start, so bit `FRAME_W-1` never hits. All other behaviour is identical.

## Test plan
All scenarios use `N_CH`=4, `FRAME_W`=8.
- **Single frame:** after reset, ch0 sends 8'b1001_0001 -> `res_ch`=0, `res_mask`=8'b0010_0110, `res_hits`=3. `res_valid` is high 8 cycles after the accepting edge.
- **Context carry:** ch2 sends 8'h00 twice.
  - First frame: `res_mask`=8'h7F, `res_hits`=7.
  - Second frame with `SEQDET_CTX_EN`: `res_mask`=8'hFF, `res_hits`=8.
  - Second frame without the macro: 8'h7F, 7.
- **Round-robin:** all four channels held valid from reset -> grant order 0,1,2,3,0. Only ch1 and ch3 valid -> grants alternate 1,3,1,3.
- **Context isolation:** ch0 sends 8'h00, then ch1 sends 8'h00, then ch0 sends 8'h80 -> ch1 `res_hits`=7; the last ch0 frame gives `res_mask`=8'h3F, `res_hits`=6.
- **Backpressure:** `res_ready` low for 5 cycles in DONE while ch3 is requesting -> result held constant, `req_ready` stays 0. After the handshake, ch3 is granted on the next edge.
- **Reset mid-SHIFT:** `rst` at bit index 4 -> no `res_valid`, outputs at reset values. The following ch0 frame 8'h00 gives `res_hits`=7, confirming the context was cleared.
